// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: operand width, funct3 codes and sequencer state encoding.
// Consumers: muldiv_sequencer, muldiv_datapath (optional MULDIV_EARLY_OUT_EN lives in the datapath).
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // rs1 is signed for every op except the fully unsigned variants
    function automatic logic rs1_signed(input logic [2:0] f3);
        return !(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
    endfunction

    // MULHSU treats rs2 as unsigned
    function automatic logic rs2_signed(input logic [2:0] f3);
        return rs1_signed(f3) && (f3 != F3_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers, shared adder-subtractor and sign fix-up for the RV32M unit.
// MULDIV_EARLY_OUT_EN: flags a zero multiply operand as a special (2-cycle) case.
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            prep,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            special,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]      op_reg;
    logic [XLEN-1:0] a_reg, b_reg, hi_reg, lo_reg, result_reg;
    logic            neg_reg;

    logic            is_div, is_rem, a_neg, b_neg, div_zero, div_ovf, early_zero;
    logic [XLEN-1:0] abs_a, abs_b, special_value, fix_value;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod, prod_fixed;
    logic [XLEN-1:0] quo_fixed, rem_fixed;

    assign is_div = op_reg[2];
    assign is_rem = op_reg[2] & op_reg[1];
    assign a_neg  = rs1_signed(op_reg) & a_reg[XLEN-1];
    assign b_neg  = rs2_signed(op_reg) & b_reg[XLEN-1];
    assign abs_a  = a_neg ? -a_reg : a_reg;
    assign abs_b  = b_neg ? -b_reg : b_reg;

    assign div_zero = is_div && (b_reg == '0);
    assign div_ovf  = is_div && rs1_signed(op_reg) && (a_reg == MIN_NEG) && (b_reg == '1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_zero = !is_div && ((a_reg == '0) || (b_reg == '0));
`else
    assign early_zero = 1'b0;
`endif

    // Only meaningful in PREP, while a_reg/b_reg still hold the raw operands
    assign special = div_zero | div_ovf | early_zero;

    always_comb begin
        special_value = '0;
        if (div_zero)
            special_value = is_rem ? a_reg : '1;
        else if (div_ovf)
            special_value = is_rem ? '0 : MIN_NEG;
    end

    // Multiply: add multiplicand into the high half when the LSB is set, then shift right
    assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract
    assign div_shift = {hi_reg, lo_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};

    assign prod       = {hi_reg, lo_reg};
    assign prod_fixed = neg_reg ? -prod : prod;
    assign quo_fixed  = neg_reg ? -lo_reg : lo_reg;
    assign rem_fixed  = neg_reg ? -hi_reg : hi_reg;

    always_comb begin
        fix_value = prod_fixed[2*XLEN-1:XLEN];
        if (is_div)
            fix_value = is_rem ? rem_fixed : quo_fixed;
        else if (op_reg == F3_MUL)
            fix_value = prod_fixed[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            if (load) begin
                op_reg <= funct3;
                a_reg  <= src_a;
                b_reg  <= src_b;
            end
            if (prep) begin
                hi_reg  <= '0;
                lo_reg  <= abs_a;
                b_reg   <= abs_b;
                neg_reg <= is_rem ? a_neg : (a_neg ^ b_neg);
                if (special)
                    result_reg <= special_value;
            end
            if (step) begin
                if (is_div) begin
                    if (!div_diff[XLEN]) begin
                        hi_reg <= div_diff[XLEN-1:0];
                        lo_reg <= {lo_reg[XLEN-2:0], 1'b1};
                    end else begin
                        hi_reg <= div_shift[XLEN-1:0];
                        lo_reg <= {lo_reg[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_reg <= mul_sum[XLEN:1];
                    lo_reg <= {mul_sum[0], lo_reg[XLEN-1:1]};
                end
            end
            if (fix)
                result_reg <= fix_value;
        end
    end

    assign result = result_reg;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle controller: IDLE/PREP/ITER/FIX/DONE FSM steering muldiv_datapath.
// Build option MULDIV_EARLY_OUT_EN is handled inside muldiv_datapath.
module muldiv_sequencer
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;
    logic             load, prep, step, fix, special;

    // Strobes are suppressed by flush so an aborted op never touches result
    assign load = (state_reg == IDLE) && start && !flush;
    assign prep = (state_reg == PREP) && !flush;
    assign step = (state_reg == ITER) && !flush;
    assign fix  = (state_reg == FIX)  && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (start) state_reg <= PREP;
                PREP: begin
                    cnt_reg <= '0;
                    if (special) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(XLEN-1))
                        state_reg <= FIX;
                end
                FIX: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy  = (state_reg != IDLE);
    assign stall = (start && state_reg == IDLE) ||
                   (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
    assign done  = done_reg;

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .prep   (prep),
        .step   (step),
        .fix    (fix),
        .funct3 (funct3),
        .src_a  (src_a),
        .src_b  (src_b),
        .special(special),
        .result (result)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: reference model from plain 64-bit arithmetic plus literal checks.
module tb_muldiv_sequencer;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, stall, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct3(funct3),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of an M instruction
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub, up;
        longint          sp;
        logic [63:0]     p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            F3_MUL:    begin sp = sa * sb; p = sp; return p[31:0]; end
            F3_MULH:   begin sp = sa * sb; p = sp; return p[63:32]; end
            F3_MULHSU: begin sp = sa * longint'(ub); p = sp; return p[63:32]; end
            F3_MULHU:  begin up = ua * ub; p = up; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sp = sa / sb; p = sp; return p[31:0];
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb; p = sp; return p[31:0];
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; p = up; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; p = up; return p[31:0];
            end
        endcase
    endfunction

    // Cycles from acceptance edge to done cycle
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 2;
            if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (!f3[2] && (a == 0 || b == 0)) return 2;
`endif
        return 35;
    endfunction

    // Model: m_left counts edges until the unit is idle again; m_left==1 is the done cycle
    int          m_left = 0;
    logic [31:0] m_pending = '0;
    logic [31:0] m_result = '0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_left   = 0;
            m_result = '0;
            m_valid  = 1'b1;
        end else if (m_left == 0) begin
            if (start && !flush) begin
                m_left    = ref_latency(funct3, src_a, src_b);
                m_pending = ref_result(funct3, src_a, src_b);
            end
        end else if (flush) begin
            m_left = 0;
        end else begin
            m_left--;
            if (m_left == 1) m_result = m_pending;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy",   {31'd0, busy},  {31'd0, m_left != 0});
            check("stall",  {31'd0, stall}, {31'd0, (m_left == 0 && start) || m_left > 1});
            check("done",   {31'd0, done},  {31'd0, m_left == 1});
            check("result", result, m_result);
        end
    end

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        start = 1'b1; funct3 = f3; src_a = a; src_b = b;
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_timeout"}, {31'd0, done}, 32'd1);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_value"}, result, exp);
        $display("op %s a=%h b=%h result=%h cycles=%0d", name, a, b, result, n);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_result", result, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        do_op("mul_7_m6",     F3_MUL,    32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 35);
        do_op("mulhu_max",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
        do_op("mulhsu_m1_2",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 35);
        do_op("mulh_min_min", F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35);
        do_op("div_m7_2",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
        do_op("rem_m7_2",     F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
        do_op("divu_by0",     F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2);
        do_op("rem_by0",      F3_REM,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 2);
        do_op("div_ovf",      F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
        do_op("rem_ovf",      F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         2);
        do_op("divu_max_3",   F3_DIVU,   32'hFFFF_FFFF,  32'd3,         32'h5555_5555, 35);
`ifdef MULDIV_EARLY_OUT_EN
        do_op("mul_x_0",      F3_MUL,    32'h0001_2345,  32'd0,         32'h0,         2);
`else
        do_op("mul_x_0",      F3_MUL,    32'h0001_2345,  32'd0,         32'h0,         35);
`endif
        do_op("remu_100_7",   F3_REMU,   32'd100,        32'd7,         32'd2,         35);

        // Abort DIVU 100/3 while the iteration counter is at 10
        start = 1'b1; funct3 = F3_DIVU; src_a = 32'd100; src_b = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result_kept", result, 32'd2);
        $display("op flush_divu busy=%0d result=%h", busy, result);
        do_op("divu_100_3",   F3_DIVU,   32'd100,        32'd3,         32'd33,        35);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; funct3 = F3_MUL; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);
        $display("op start_with_flush busy=%0d", busy);

        // reset in the middle of a multiply clears result
        start = 1'b1; funct3 = F3_MUL; src_a = 32'd3; src_b = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        check("midop_reset_result", result, 32'd0);
        $display("op midop_reset busy=%0d result=%h", busy, result);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
